// File: rtl/text_display_gen.sv
// text_display_gen
// Raster timing generator and COLS x ROWS character renderer for a terminal
// display. Characters arrive over a valid/ready stream and are written into an
// internal dual-port VRAM. The raster side reads the VRAM, looks up glyphs in
// an external font ROM and produces a monochrome pixel stream with syncs.
// Scrolling rotates a top-row pointer instead of moving VRAM data. A small FSM
// blanks the freshly exposed bottom row after a scroll and blanks the whole
// screen after reset or on request.
//
// Optional build macro: CURSOR_BLINK_EN adds a free-running blink divider so
// the cursor cell alternates between code 0x00 and code 0x20. Without it the
// cursor cell is a solid code 0x00.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pix_en          pixel clock enable for the raster counters and pipeline
//   clr_screen      level request: clear screen and home the cursor
//   ch_valid/ch_data/ch_ready   character input stream
//   font_addr       {glyph code, cell line} to the external font ROM
//   font_data       font ROM row, one pix_en tick after font_addr, MSB leftmost
//   hsync, vsync    active-low syncs, aligned with pix
//   de              display enable, aligned with pix
//   pix             monochrome pixel, 0 outside de
//   cur_col/cur_row cursor position (logical row)
module text_display_gen #(
  parameter int COLS       = 40,
  parameter int ROWS       = 24,
  parameter int CHAR_W     = 16,
  parameter int CHAR_H     = 8,
  parameter int H_TOTAL    = 910,
  parameter int V_TOTAL    = 262,
  parameter int H_SYNC     = 65,
  parameter int V_SYNC     = 2,
  parameter int H_START    = 208,
  parameter int V_START    = 42,
  parameter int BLINK_BITS = 23
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_en,
  input  logic                          clr_screen,
  input  logic                          ch_valid,
  input  logic [7:0]                    ch_data,
  output logic                          ch_ready,
  output logic [6+$clog2(CHAR_H)-1:0]   font_addr,
  input  logic [CHAR_W-1:0]             font_data,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          de,
  output logic                          pix,
  output logic [$clog2(COLS)-1:0]       cur_col,
  output logic [$clog2(ROWS)-1:0]       cur_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int RW1   = RW + 1;
  localparam int LW    = $clog2(CHAR_H);
  localparam int OW    = $clog2(CHAR_W);
  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int H_END = H_START + COLS * CHAR_W;
  localparam int V_END = V_START + ROWS * CHAR_H;

  typedef enum logic [1:0] {ST_IDLE, ST_CLR_ROW, ST_CLR_ALL} state_t;

  // ---------------------------------------------------------------- raster
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Raster counters advance only on pixel-enable ticks.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == VW'(V_TOTAL - 1)) begin
          v_d = '0;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end else begin
      h_d = h_q;
    end
  end

  // ------------------------------------------------------ write-side state
  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   clr_base_q, clr_base_d;
  logic [CW-1:0]   cur_col_q, cur_col_d;
  logic [RW-1:0]   cur_row_q, cur_row_d;
  logic [RW-1:0]   top_row_q, top_row_d;
  logic            we_s;
  logic [AW-1:0]   waddr_s;
  logic [5:0]      wdata_s;
  logic            nl_s;
  logic [RW1-1:0]  wsum_s;
  logic [RW-1:0]   wrow_s;

  assign ch_ready = (state_q == ST_IDLE) && !clr_screen;

  // Physical VRAM row under the cursor (logical row rotated by top_row).
  always_comb begin
    wsum_s = RW1'(top_row_q) + RW1'(cur_row_q);
    if (wsum_s >= RW1'(ROWS)) begin
      wrow_s = RW'(wsum_s - RW1'(ROWS));
    end else begin
      wrow_s = RW'(wsum_s);
    end
  end

  // Character handling, scrolling and clear sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_base_d = clr_base_q;
    cur_col_d  = cur_col_q;
    cur_row_d  = cur_row_q;
    top_row_d  = top_row_q;
    we_s       = 1'b0;
    waddr_s    = '0;
    wdata_s    = 6'h20;
    nl_s       = 1'b0;
    if (clr_screen) begin
      // Held request keeps the sweep parked at cell 0.
      state_d   = ST_CLR_ALL;
      cnt_d     = '0;
      cur_col_d = '0;
      cur_row_d = '0;
      top_row_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ch_valid) begin
            case (ch_data)
              8'h0D, 8'h8D: nl_s = 1'b1;
              8'h00, 8'h0A, 8'h7F, 8'h9B: nl_s = 1'b0;
              default: begin
                we_s    = 1'b1;
                waddr_s = AW'(wrow_s) * AW'(COLS) + AW'(cur_col_q);
                wdata_s = {~ch_data[6], ch_data[4:0]};
                if (cur_col_q == CW'(COLS - 1)) begin
                  nl_s = 1'b1;
                end else begin
                  cur_col_d = cur_col_q + CW'(1);
                end
              end
            endcase
          end else begin
            nl_s = 1'b0;
          end
          if (nl_s) begin
            cur_col_d = '0;
            if (cur_row_q < RW'(ROWS - 1)) begin
              cur_row_d = cur_row_q + RW'(1);
            end else begin
              // Old top physical row becomes the new bottom row.
              top_row_d  = (top_row_q == RW'(ROWS - 1)) ? '0 : top_row_q + RW'(1);
              clr_base_d = AW'(top_row_q) * AW'(COLS);
              cnt_d      = '0;
              state_d    = ST_CLR_ROW;
            end
          end else begin
            cur_col_d = cur_col_d;
          end
        end
        ST_CLR_ROW: begin
          we_s    = 1'b1;
          waddr_s = clr_base_q + cnt_q;
          if (cnt_q == AW'(COLS - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        ST_CLR_ALL: begin
          we_s    = 1'b1;
          waddr_s = cnt_q;
          if (cnt_q == AW'(CELLS - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------- display address
  logic            act_s;
  logic [HW-1:0]   h_rel_s;
  logic [VW-1:0]   v_rel_s;
  logic [CW-1:0]   h_cell_s;
  logic [OW-1:0]   h_off_s;
  logic [RW-1:0]   v_cell_s;
  logic [LW-1:0]   v_line_s;
  logic [RW1-1:0]  rsum_s;
  logic [RW-1:0]   rrow_s;
  logic [AW-1:0]   raddr_s;
  logic            is_cur_s;

  // Cell coordinates for the current raster position; forced to 0 outside
  // the active area so the VRAM index always stays in range.
  always_comb begin
    act_s   = (h_q >= HW'(H_START)) && (h_q < HW'(H_END)) &&
              (v_q >= VW'(V_START)) && (v_q < VW'(V_END));
    h_rel_s = h_q - HW'(H_START);
    v_rel_s = v_q - VW'(V_START);
    if (act_s) begin
      h_cell_s = CW'(h_rel_s / HW'(CHAR_W));
      h_off_s  = OW'(h_rel_s % HW'(CHAR_W));
      v_cell_s = RW'(v_rel_s / VW'(CHAR_H));
      v_line_s = LW'(v_rel_s % VW'(CHAR_H));
    end else begin
      h_cell_s = '0;
      h_off_s  = '0;
      v_cell_s = '0;
      v_line_s = '0;
    end
    rsum_s = RW1'(top_row_q) + RW1'(v_cell_s);
    if (rsum_s >= RW1'(ROWS)) begin
      rrow_s = RW'(rsum_s - RW1'(ROWS));
    end else begin
      rrow_s = RW'(rsum_s);
    end
    raddr_s  = AW'(rrow_s) * AW'(COLS) + AW'(h_cell_s);
    is_cur_s = act_s && (v_cell_s == cur_row_q) && (h_cell_s == cur_col_q);
  end

  // ------------------------------------------------------------------ VRAM
  logic [5:0] vram [CELLS];
  logic [5:0] rd_code_q;

  // Dual-port store: write port for the FSM, registered read for the raster.
  always_ff @(posedge clk) begin
    if (we_s) begin
      vram[waddr_s] <= wdata_s;
    end
    if (pix_en) begin
      rd_code_q <= vram[raddr_s];
    end
  end

  // ---------------------------------------------------------------- cursor
  logic [5:0] cursor_code_s;
`ifdef CURSOR_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic                  blink_q, blink_d;

  // Blink phase flips each time the free-running divider wraps.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
    if (&blink_cnt_q) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  // Blink divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign cursor_code_s = blink_q ? 6'h00 : 6'h20;
`else
  assign cursor_code_s = 6'h00;
`endif

  // ------------------------------------------------------- pixel pipeline
  logic          cur1_q;
  logic [LW-1:0] line1_q;
  logic [OW-1:0] off1_q, off2_q;
  logic          hs1_q, vs1_q, de1_q;
  logic          hs2_q, vs2_q, de2_q;
  logic          hsync_q, vsync_q, de_q, pix_q;

  assign font_addr = {(cur1_q ? cursor_code_s : rd_code_q), line1_q};

  // State registers and the three pipeline stages (stage 2 waits on the ROM).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      state_q    <= ST_CLR_ALL;
      cnt_q      <= '0;
      clr_base_q <= '0;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      top_row_q  <= '0;
      cur1_q     <= 1'b0;
      line1_q    <= '0;
      off1_q     <= '0;
      off2_q     <= '0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      de1_q      <= 1'b0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
      de2_q      <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      de_q       <= 1'b0;
      pix_q      <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_base_q <= clr_base_d;
      cur_col_q  <= cur_col_d;
      cur_row_q  <= cur_row_d;
      top_row_q  <= top_row_d;
      if (pix_en) begin
        cur1_q  <= is_cur_s;
        line1_q <= v_line_s;
        off1_q  <= h_off_s;
        hs1_q   <= (h_q >= HW'(H_SYNC));
        vs1_q   <= (v_q >= VW'(V_SYNC));
        de1_q   <= act_s;
        off2_q  <= off1_q;
        hs2_q   <= hs1_q;
        vs2_q   <= vs1_q;
        de2_q   <= de1_q;
        hsync_q <= hs2_q;
        vsync_q <= vs2_q;
        de_q    <= de2_q;
        pix_q   <= de2_q & font_data[OW'(CHAR_W - 1) - off2_q];
      end else begin
        pix_q   <= pix_q;
      end
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign de      = de_q;
  assign pix     = pix_q;
  assign cur_col = cur_col_q;
  assign cur_row = cur_row_q;

endmodule

// File: tb/tb_text_display_gen.sv
// Self-checking bench for text_display_gen at default geometry.
module tb_text_display_gen;

  logic        clk = 1'b0;
  logic        rst, pix_en, clr_screen, ch_valid, ch_ready;
  logic [7:0]  ch_data;
  logic [8:0]  font_addr;
  logic [15:0] font_data = 16'h0000;
  logic        hsync, vsync, de, pix;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;

  int n_chk = 0;
  int n_fail = 0;

  // Bench-side screen model
  logic [5:0] mvram [960];
  int mcol, mrow, mtop;
  logic [3:0] sb_q [$];

  typedef struct {
    logic [7:0] ch;
    int         col;
    int         row;
  } vec_t;
  vec_t vecs [9];

  text_display_gen dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .clr_screen(clr_screen),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .font_addr(font_addr), .font_data(font_data),
    .hsync(hsync), .vsync(vsync), .de(de), .pix(pix),
    .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] font_fn(input logic [8:0] a);
    return {a[8:3], 1'b1, a[2:0], a[8:3] ^ 6'h2A};
  endfunction

  // Font ROM: one pix_en tick of latency
  always @(posedge clk) begin
    if (pix_en) font_data <= font_fn(font_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] code_of(input logic [7:0] c);
    return {~c[6], c[4:0]};
  endfunction

  task automatic model_nl();
    mcol = 0;
    if (mrow < 23) mrow++;
    else begin
      for (int i = 0; i < 40; i++) mvram[mtop*40 + i] = 6'h20;
      mtop = (mtop + 1) % 24;
    end
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c == 8'h0D || c == 8'h8D) model_nl();
    else if (c == 8'h00 || c == 8'h0A || c == 8'h7F || c == 8'h9B) mcol = mcol;
    else begin
      mvram[((mtop + mrow) % 24)*40 + mcol] = code_of(c);
      if (mcol == 39) model_nl();
      else mcol++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 960; i++) mvram[i] = 6'h20;
    mcol = 0; mrow = 0; mtop = 0;
  endtask

  task automatic vram_check(input string name);
    int bad = 0;
    for (int i = 0; i < 960; i++) if (dut.vram[i] !== mvram[i]) bad++;
    chk(name, bad, 0);
  endtask

  // Called at a negedge; returns at a negedge after the transfer.
  task automatic send(input logic [7:0] c);
    int w = 0;
    ch_data = c;
    ch_valid = 1'b1;
    while (!ch_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!ch_ready) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
    model_char(c);
  endtask

  function automatic logic [3:0] exp_out(input int h, input int v);
    logic hs, vs, d, p;
    int vr, ln, col, off;
    logic [5:0] code;
    logic [15:0] f;
    hs = (h >= 65);
    vs = (v >= 2);
    d = (h >= 208) && (h < 848) && (v >= 42) && (v < 234);
    p = 1'b0;
    if (d) begin
      vr = (v - 42) / 8;  ln = (v - 42) % 8;
      col = (h - 208) / 16; off = (h - 208) % 16;
      if (vr == mrow && col == mcol) code = 6'h00;
      else code = mvram[((mtop + vr) % 24)*40 + col];
      f = font_fn({code, 3'(ln)});
      p = f[15 - off];
    end
    return {hs, vs, d, p};
  endfunction

  initial begin
    int cnt, hm, vm;
    logic de_seen;
    logic [3:0] e;

    vecs[0] = '{8'h41, 1, 0};
    vecs[1] = '{8'h8D, 0, 1};
    vecs[2] = '{8'h00, 0, 1};
    vecs[3] = '{8'h0A, 0, 1};
    vecs[4] = '{8'h7F, 0, 1};
    vecs[5] = '{8'h9B, 0, 1};
    vecs[6] = '{8'h7A, 1, 1};
    vecs[7] = '{8'h0D, 0, 2};
    vecs[8] = '{8'hC1, 1, 2};

    rst = 1'b1; pix_en = 1'b0; clr_screen = 1'b0; ch_valid = 1'b0; ch_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {28'd0, hsync, vsync, de, pix}, 32'hC);
    chk("rst_ready", ch_ready, 0);
    chk("rst_cursor", {cur_col, cur_row}, 0);
    rst = 1'b0;
    repeat (962) @(negedge clk);
    model_clear();
    chk("init_ready", ch_ready, 1);
    chk("init_cursor", {cur_col, cur_row}, 0);
    chk("init_top", dut.top_row_q, 0);
    vram_check("vram_init");

    // Table-driven character handling
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].ch);
      chk("vec_col", cur_col, vecs[i].col);
      chk("vec_row", cur_row, vecs[i].row);
      chk("vec_ready", ch_ready, 1);
    end
    chk("vram_00", dut.vram[0], 6'h01);
    vram_check("vram_table");

    // Clear pulse with a character offered at the same time
    ch_data = 8'h41; ch_valid = 1'b1; clr_screen = 1'b1;
    @(negedge clk);
    clr_screen = 1'b0;
    cnt = 0;
    while (!ch_ready && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    ch_valid = 1'b0;
    model_clear();
    chk("clr_ready_low", cnt, 960);
    chk("clr_cursor", {cur_col, cur_row}, 0);
    @(negedge clk);
    vram_check("vram_clear");

    // Fill row 0 exactly; wrap must not touch column 40
    for (int i = 0; i < 40; i++) send(8'h41 + 8'(i % 26));
    chk("wrap_col", cur_col, 0);
    chk("wrap_row", cur_row, 1);
    chk("wrap_no_col40", dut.vram[40], 6'h20);
    for (int i = 0; i < 40; i++) send(8'h21 + 8'(i));
    repeat (21) send(8'h0D);
    chk("bottom_row", cur_row, 23);
    vram_check("vram_fill");

    // Scroll from the bottom row
    ch_data = 8'h0D; ch_valid = 1'b1;
    cnt = 0;
    while (!ch_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
    model_char(8'h0D);
    cnt = 0;
    while (!ch_ready && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("scroll_ready_low", cnt, 40);
    chk("scroll_top", dut.top_row_q, 1);
    chk("scroll_cursor", {cur_col, 3'd0, cur_row}, {6'd0, 3'd0, 5'd23});
    vram_check("vram_scroll");

    // Raster scoreboard over the first 60 lines
    sb_q.push_back(4'b1100);
    sb_q.push_back(4'b1100);
    pix_en = 1'b1;
    hm = 0; vm = 0; de_seen = 1'b0;
    for (int t = 0; t < 60*910; t++) begin
      @(posedge clk);
      sb_q.push_back(exp_out(hm, vm));
      if (hm == 909) begin
        hm = 0;
        vm = (vm == 261) ? 0 : vm + 1;
      end else hm++;
      @(negedge clk);
      e = sb_q.pop_front();
      chk("raster", {28'd0, hsync, vsync, de, pix}, {28'd0, e});
      if (!de_seen && de) begin
        de_seen = 1'b1;
        chk("de_start_h", hm, 211);
        chk("de_start_v", vm, 42);
      end
    end
    chk("de_seen", de_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/text_display_gen.md
Name: text_display_gen

Overview:
- Parametrised successor to the fixed 40x24 Apple-1 text display.
- Generates raster timing and renders a COLS x ROWS character screen from an internal dual-port VRAM through an external font ROM.
- Accepts terminal characters over a valid/ready stream.
- Adds what the fixed block lacks: configurable geometry and timing, a ready handshake, hardware scroll through a top-row pointer, and deterministic FSM-driven clears of the new bottom row and of the whole screen.
- Sits between the CPU's PIA TX register logic and the video DAC.

Parameters:
- COLS, 40, characters per row.
- ROWS, 24, character rows.
- CHAR_W, 16, pixels per cell horizontally (width of font_data).
- CHAR_H, 8, lines per cell vertically.
- H_TOTAL, 910, pixel periods per line; h counter runs 0..H_TOTAL-1.
- V_TOTAL, 262, lines per frame; v counter runs 0..V_TOTAL-1.
- H_SYNC, 65, hsync low while h < H_SYNC.
- V_SYNC, 2, vsync low while v < V_SYNC.
- H_START, 208, first active pixel; active width is COLS*CHAR_W.
- V_START, 42, first active line; active height is ROWS*CHAR_H.
- BLINK_BITS, 23, cursor blink divider width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_en  in  1  pixel clock enable; raster counters and pipeline advance only when high
- clr_screen  in  1  level request to clear the screen and home the cursor
- ch_valid  in  1  character offered
- ch_data  in  8  ASCII character (bit 7 ignored for printables)
- ch_ready  out  1  block can accept a character this cycle
- font_addr  out  6+clog2(CHAR_H)  {code, cell line}
- font_data  in  CHAR_W  font row; valid 1 pix_en tick after font_addr; MSB is leftmost pixel
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  display enable
- pix  out  1  monochrome pixel (0 outside de)
- cur_col  out  clog2(COLS)  cursor column
- cur_row  out  clog2(ROWS)  cursor logical row

Behaviour:
- Reset: h=v=0; hsync=vsync=1; de=pix=0; cur_col=cur_row=0; top_row=0; state=CLR_ALL with ch_ready=0. VRAM content is undefined until the reset-triggered CLR_ALL finishes.
- Raster: on pix_en, h increments; at H_TOTAL-1 it wraps to 0 and v increments; v wraps at V_TOTAL-1.
- Active region: H_START <= h < H_START+COLS*CHAR_W, and likewise for v.
- Pixel pipeline, 3 pix_en ticks, applied to all outputs:
  - t0: VRAM read at physical row (top_row + v_cell) mod ROWS, column h_cell.
  - t1: registered code drives font_addr.
  - t2: font_data arrives.
  - t3: pix = font_data[CHAR_W-1-h_off].
  - hsync, vsync and de are delayed 3 ticks to stay aligned with pix.
- Cursor cell: when the display cell equals (cur_row, cur_col), code 0 is substituted (see the optional feature for blink).
- Stored code: {~ch_data[6], ch_data[4:0]}.
- FSM IDLE, ch_ready = ~clr_screen. A transfer occurs when ch_valid & ch_ready. Handling by character:
  - 0x0D/0x8D: newline.
  - 0x00, 0x0A, 0x7F, 0x9B: accepted and ignored; no state change.
  - Anything else: write VRAM at physical (top_row+cur_row, cur_col), then cur_col++. If cur_col was COLS-1, set cur_col=0 and perform a newline.
- Newline: cur_col=0.
  - If cur_row < ROWS-1: cur_row++.
  - Otherwise top_row = (top_row+1) mod ROWS, cur_row stays ROWS-1, go to CLR_ROW.
- CLR_ROW: writes code 0x20 to the new bottom physical row, one cell per clk (not gated by pix_en), COLS cycles. ch_ready=0. Returns to IDLE.
- CLR_ALL: entered from any state when clr_screen=1. Sets top_row=cur_row=cur_col=0 immediately, then writes 0x20 to all ROWS*COLS cells, one per clk. ch_ready=0.
  - clr_screen held high restarts the count each cycle.
  - clr_screen asserted during CLR_ROW aborts the row clear.
- Simultaneous events: clr_screen beats ch_valid, and the character is not accepted. Display reads are never stalled by writes; a cell written mid-frame may show old or new data for that frame.
- rst mid-clear: everything returns to reset values, and the clear restarts from cell 0.

Optional Feature:
- CURSOR_BLINK_EN defined: a free-running BLINK_BITS counter toggles blink at wrap. The cursor cell shows code 0 when blink=1 and 0x20 when blink=0.
- Undefined: the cursor cell always shows code 0 (solid); no divider is built.

Test Plan:
- Reset then wait ROWS*COLS+2 clks -> ch_ready=1, cur_col=0, cur_row=0; every VRAM cell =0x20.
- Send 'A' (0x41) -> VRAM(0,0)=0x01, cur_col=1. Send 0x8D -> cur_col=0, cur_row=1.
- Send 40 printables at row 0 (COLS=40) -> cur_col=0, cur_row=1; no write lands at column 40.
- At cur_row=23, send 0x0D -> top_row=1; ch_ready=0 for exactly 40 clks; physical row 0 all 0x20; de-aligned pix shows old row 1 as the top line.
- Hold ch_valid with 0x41 while pulsing clr_screen for 1 clk -> no character accepted; ch_ready=0 for 960 clks; cursor at (0,0).
- Raster check with pix_en=1 every clk: hsync low for 65 ticks every 910; vsync low for 2 lines per 262; de high for 640 pixels x 192 lines, starting 3 ticks after h=208, v=42.
